// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared definitions for the RAM-backed FIFO controller.
// Holds the default data/address widths, the depth derivation used by the
// controller and the RAM model, and the head-register state encoding.
package ram_fifo_ctrl_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 6;

   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction

   typedef enum logic {
      HEAD_EMPTY = 1'b0,
      HEAD_VALID = 1'b1
   } head_state_t;

endpackage

// File: rtl/ram_fifo.sv
// Thin wrapper: FIFO controller plus its RAM, exposing only the stream side.
// Ports:
//   clk, rst_n                   - clock, async active-low reset
//   in_valid/in_ready/in_data    - upstream stream
//   out_valid/out_ready/out_data - downstream stream
//   count/full/empty             - occupancy
module ram_fifo
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty
);

   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_write_addr, ram_read_addr;
   logic [DATA_WIDTH-1:0] ram_data, ram_q;

   ram_fifo_ctrl #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ctrl (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .ram_we         (ram_we),
      .ram_write_addr (ram_write_addr),
      .ram_data       (ram_data),
      .ram_read_addr  (ram_read_addr),
      .ram_q          (ram_q),
      .count          (count),
      .full           (full),
      .empty          (empty)
   );

   ram_single_port2 #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk        (clk),
      .we         (ram_we),
      .write_addr (ram_write_addr),
      .data       (ram_data),
      .read_addr  (ram_read_addr),
      .q          (ram_q)
   );

endmodule

// File: rtl/ram_single_port2.sv
// Single-port RAM with separate read and write addresses and a registered,
// write-first read port: a read of the address being written returns the new
// data. Contents are not reset.
// Ports:
//   clk        - clock, all updates on posedge
//   we         - write enable
//   write_addr - write address
//   data       - write data
//   read_addr  - read address
//   q          - registered read data
module ram_single_port2
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] q
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[write_addr] <= data;
      end
      q <= (we && (write_addr == read_addr)) ? data : mem[read_addr];
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that turns an external single-port RAM with a registered
// read port into a valid/ready stream buffer.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   in_valid/in_ready/in_data  - upstream stream
//   out_valid/out_ready/out_data - downstream stream, out_data is ram_q
//   ram_we/ram_write_addr/ram_data/ram_read_addr/ram_q - RAM interface
//   count/full/empty           - occupancy, including the presented head word
//
// Head register FSM:
//   state      | meaning
//   HEAD_EMPTY | ram_q holds nothing meaningful, out_valid=0
//   HEAD_VALID | ram_q holds the FIFO head, out_valid=1
module ram_fifo_ctrl
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_write_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

   head_state_t           state, state_nxt;
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]   count_r, avail;
   logic                  push, pop, fetch;

   assign out_valid = (state == HEAD_VALID);
   assign full      = (count_r == FULL_COUNT);
   assign empty     = (count_r == '0);
   assign in_ready  = !full;
   assign count     = count_r;

   assign push  = in_valid && in_ready;
   assign pop   = out_valid && out_ready;
   // Entries sitting in RAM that have not been moved into the head register yet.
   assign avail = count_r - {{ADDR_WIDTH{1'b0}}, out_valid};
   // Based on registered count only, so a word is never read in its write cycle.
   assign fetch = (avail != '0) && (!out_valid || out_ready);

   assign ram_we         = push;
   assign ram_write_addr = wr_ptr;
   assign ram_data       = in_data;
   // While not fetching, re-read the presented slot so ram_q stays stable.
   assign ram_read_addr  = fetch ? rd_ptr : (rd_ptr - PTR_ONE);
   assign out_data       = ram_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HEAD_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (fetch) begin
         state_nxt = HEAD_VALID;
      end else if (pop) begin
         state_nxt = HEAD_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_r <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (fetch) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         // A slot is released only on pop, so the presented slot is never rewritten.
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed and random checks of ram_fifo_ctrl wired to ram_single_port2.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_data, out_data, ram_data, ram_q;
   logic       ram_we;
   logic [5:0] ram_write_addr, ram_read_addr;
   logic [6:0] count;
   logic       full, empty;

   int checks = 0;
   int errors = 0;
   logic [7:0] model_q[$];
   logic [7:0] exp_next;

   always #5 clk = ~clk;

   ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .ram_we         (ram_we),
      .ram_write_addr (ram_write_addr),
      .ram_data       (ram_data),
      .ram_read_addr  (ram_read_addr),
      .ram_q          (ram_q),
      .count          (count),
      .full           (full),
      .empty          (empty)
   );

   ram_single_port2 #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) u_ram (
      .clk        (clk),
      .we         (ram_we),
      .write_addr (ram_write_addr),
      .data       (ram_data),
      .read_addr  (ram_read_addr),
      .q          (ram_q)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, update the scoreboard with the
   // handshakes that will fire on the coming edge, then advance to 1 after it.
   task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      #1;
      if (out_valid && ordy) begin
         chk("pop_nonempty", 32'(model_q.size() != 0), 32'd1);
         if (model_q.size() != 0) begin
            chk("pop_data", 32'(out_data), 32'(model_q[0]));
            void'(model_q.pop_front());
         end
      end
      if (iv && in_ready) begin
         model_q.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && model_q.size() != 0; i++) begin
         cyc(1'b0, 8'h00, 1'b1);
      end
      chk(tag, 32'(model_q.size()), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      rst_n = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_out_valid", 32'(out_valid), 32'd0);

      // Single word
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      #1;
      chk("push_we", 32'(ram_we), 32'd1);
      chk("push_waddr", 32'(ram_write_addr), 32'd0);
      chk("push_wdata", 32'(ram_data), 32'hA5);
      cyc(1'b1, 8'hA5, 1'b1);
      chk("single_count_n", 32'(count), 32'd1);
      chk("single_ov_n", 32'(out_valid), 32'd0);
      chk("single_raddr_fetch", 32'(ram_read_addr), 32'd0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("single_ov_n1", 32'(out_valid), 32'd1);
      chk("single_data_n1", 32'(out_data), 32'hA5);
      cyc(1'b0, 8'h00, 1'b1);
      chk("single_empty", 32'(empty), 32'd1);
      chk("single_ov_after", 32'(out_valid), 32'd0);

      // Stall hold
      cyc(1'b1, 8'h11, 1'b0);
      cyc(1'b1, 8'h22, 1'b0);
      cyc(1'b1, 8'h33, 1'b0);
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_data", 32'(out_data), 32'h11);
         chk("stall_count", 32'(count), 32'd3);
         cyc(1'b0, 8'h00, 1'b0);
      end
      chk("stall_raddr_hold", 32'(ram_read_addr), 32'd1);
      chk("rel_data0", 32'(out_data), 32'h11);
      cyc(1'b0, 8'h00, 1'b1);
      chk("rel_data1", 32'(out_data), 32'h22);
      cyc(1'b0, 8'h00, 1'b1);
      chk("rel_data2", 32'(out_data), 32'h33);
      cyc(1'b0, 8'h00, 1'b1);
      chk("rel_empty", 32'(empty), 32'd1);

      // Fill to full (pointers start at 4, so this wraps)
      for (int i = 0; i < 64; i++) begin
         cyc(1'b1, 8'(i), 1'b0);
      end
      chk("fill_count", 32'(count), 32'd64);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      chk("fill_empty", 32'(empty), 32'd0);
      cyc(1'b1, 8'hFF, 1'b0);
      chk("full_ignore_count", 32'(count), 32'd64);
      chk("full_ignore_we", 32'(ram_we), 32'd0);
      // Push attempt while popping at full is still refused.
      chk("drain_d0", 32'(out_data), 32'h00);
      cyc(1'b1, 8'hFF, 1'b1);
      chk("full_pop_count", 32'(count), 32'd63);
      for (int i = 1; i < 64; i++) begin
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_data", 32'(out_data), 32'(i));
         cyc(1'b0, 8'h00, 1'b1);
      end
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_count", 32'(count), 32'd0);

      // Streaming across pointer wrap
      exp_next = 8'h00;
      for (int k = 0; k < 200; k++) begin
         if (k >= 2) chk("stream_valid", 32'(out_valid), 32'd1);
         if (out_valid) begin
            chk("stream_data", 32'(out_data), 32'(exp_next));
            exp_next = exp_next + 8'd1;
         end
         chk("stream_count_le2", 32'(count <= 7'd2), 32'd1);
         cyc(1'b1, 8'(k), 1'b1);
      end
      drain("stream_drain");
      chk("stream_total", 32'(exp_next), 32'd198);

      // Reset mid-stream takes effect without a clock
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0);
      chk("pre_rst_count", 32'(count), 32'd5);
      chk("pre_rst_ov", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_ov", 32'(out_valid), 32'd0);
      chk("async_rst_empty", 32'(empty), 32'd1);
      model_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);
      chk("post_rst_count", 32'(count), 32'd0);

      // Random traffic against the scoreboard
      for (int c = 0; c < 5000; c++) begin
         chk("rand_count", 32'(count), 32'(model_q.size()));
         chk("rand_full", 32'(full), 32'(model_q.size() == 64));
         cyc(1'($urandom_range(0, 99) < ((c / 1000) % 2 == 0 ? 70 : 40)),
             8'($urandom),
             1'($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 40 : 80)));
      end
      drain("rand_drain");
      chk("rand_end_empty", 32'(empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
